// File: rtl/data_bus_slave_pkg.sv
// rtl/data_bus_slave_pkg.sv - register map, unmapped-read pattern and FSM states for data_bus_slave
package data_bus_slave_pkg;

    localparam logic [31:0] OFF_GPIO   = 32'h0000_0000;
    localparam logic [31:0] OFF_TCOUNT = 32'h0000_0004;
    localparam logic [31:0] OFF_TCMP   = 32'h0000_0008;
    localparam logic [31:0] OFF_STATUS = 32'h0000_000C;

    localparam logic [31:0] BUS_UNMAPPED_DATA = 32'hDEDE_AFAF;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

endpackage

// File: rtl/data_bus_slave_if.sv
// rtl/data_bus_slave_if.sv - cpu data bus: strobe, direction, byte address, write and read data
interface data_bus_slave_if;

    logic        cs;
    logic        we;
    logic [31:0] ADDR;
    logic [31:0] DATA_BUS_WRITE;
    logic [31:0] DATA_BUS_READ;

    modport master (
        output cs,
        output we,
        output ADDR,
        output DATA_BUS_WRITE,
        input  DATA_BUS_READ
    );

    modport slave (
        input  cs,
        input  we,
        input  ADDR,
        input  DATA_BUS_WRITE,
        output DATA_BUS_READ
    );

endinterface

// File: rtl/data_bus_timer.sv
// rtl/data_bus_timer.sv - free-running compare timer with sticky match-pending flag
module data_bus_timer (
    input  logic        clkIn,
    input  logic        rst,
    input  logic        run,
    input  logic        wr_count,
    input  logic        wr_cmp,
    input  logic        clr_pend,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic        pend
);

    logic match;

    assign match = run && (cmp != 32'h0) && (count == cmp);

    always_ff @(posedge clkIn) begin
        if (!rst) begin
            count <= '0;
            cmp   <= '0;
            pend  <= 1'b0;
        end else begin
            // Any write to the count register restarts it, overriding the increment.
            if (wr_count) begin
                count <= '0;
            end else if (run) begin
                count <= count + 32'd1;
            end

            if (wr_cmp) begin
                cmp <= wdata;
            end

            // A match in the same cycle as a W1C clear keeps the flag set.
            if (match) begin
                pend <= 1'b1;
            end else if (clr_pend) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/data_bus_slave.sv
// rtl/data_bus_slave.sv - cpu data-bus slave: cleared RAM, GPIO, status and optional timer (DATA_BUS_SLAVE_TIMER_EN)
module data_bus_slave
    import data_bus_slave_pkg::*;
#(
    parameter int          ADDR_W  = 8,
    parameter logic [31:0] IO_BASE = 32'h0000_1000
) (
    input  logic                    clkIn,
    input  logic                    rst,
    data_bus_slave_if.slave         bus,
    output logic [15:0]             gpio_out,
    output logic                    irq,
    output logic                    err,
    output logic                    init_done
);

    localparam int          DEPTH     = 1 << ADDR_W;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH) * 32'd4;

    state_t            state;
    logic [ADDR_W-1:0] clr_idx;
    logic [31:0]       ram [DEPTH];

    logic              run_acc;
    logic              misaligned;
    logic              acc_ram;
    logic              acc_gpio;
    logic              acc_tcount;
    logic              acc_tcmp;
    logic              acc_status;
    logic              hit;
    logic              acc_ok;
    logic              acc_bad;
    logic              wr_ok;
    logic              rd_req;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       io_rdata;

    logic [31:0]       tcount;
    logic [31:0]       tcmp;
    logic              tpend;

    always_comb begin
        run_acc    = (state == ST_RUN) && bus.cs;
        misaligned = bus.ADDR[1:0] != 2'b00;
        acc_ram    = bus.ADDR < RAM_BYTES;
        acc_gpio   = bus.ADDR == (IO_BASE + OFF_GPIO);
        acc_tcount = bus.ADDR == (IO_BASE + OFF_TCOUNT);
        acc_tcmp   = bus.ADDR == (IO_BASE + OFF_TCMP);
        acc_status = bus.ADDR == (IO_BASE + OFF_STATUS);
        hit        = acc_ram || acc_gpio || acc_tcount || acc_tcmp || acc_status;
        acc_ok     = run_acc && !misaligned && hit;
        acc_bad    = run_acc && (misaligned || !hit);
        wr_ok      = acc_ok && bus.we;
        rd_req     = run_acc && !bus.we;
        ram_idx    = bus.ADDR[ADDR_W+1:2];

        io_rdata = '0;
        if (acc_gpio) begin
            io_rdata = {16'h0000, gpio_out};
        end else if (acc_tcount) begin
            io_rdata = tcount;
        end else if (acc_tcmp) begin
            io_rdata = tcmp;
        end else if (acc_status) begin
            io_rdata = {30'h0, err, tpend};
        end
    end

    // Clear sweep: one word per cycle, RUN entered as the last word is written.
    always_ff @(posedge clkIn) begin
        if (!rst) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            init_done <= 1'b0;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == {ADDR_W{1'b1}}) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (rst) begin
            if (state == ST_CLEAR) begin
                ram[clr_idx] <= '0;
            end else if (wr_ok && acc_ram) begin
                ram[ram_idx] <= bus.DATA_BUS_WRITE;
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rst) begin
            bus.DATA_BUS_READ <= '0;
            gpio_out          <= '0;
            err               <= 1'b0;
        end else begin
            if (rd_req) begin
                if (acc_bad) begin
                    bus.DATA_BUS_READ <= BUS_UNMAPPED_DATA;
                end else if (acc_ram) begin
                    bus.DATA_BUS_READ <= ram[ram_idx];
                end else begin
                    bus.DATA_BUS_READ <= io_rdata;
                end
            end

            if (wr_ok && acc_gpio) begin
                gpio_out <= bus.DATA_BUS_WRITE[15:0];
            end

            if (acc_bad) begin
                err <= 1'b1;
            end else if (wr_ok && acc_status && bus.DATA_BUS_WRITE[1]) begin
                err <= 1'b0;
            end
        end
    end

`ifdef DATA_BUS_SLAVE_TIMER_EN
    data_bus_timer u_timer (
        .clkIn    (clkIn),
        .rst      (rst),
        .run      (state == ST_RUN),
        .wr_count (wr_ok && acc_tcount),
        .wr_cmp   (wr_ok && acc_tcmp),
        .clr_pend (wr_ok && acc_status && bus.DATA_BUS_WRITE[0]),
        .wdata    (bus.DATA_BUS_WRITE),
        .count    (tcount),
        .cmp      (tcmp),
        .pend     (tpend)
    );
`else
    // Timer registers still decode (no bus error) but hold no state.
    assign tcount = '0;
    assign tcmp   = '0;
    assign tpend  = 1'b0;
`endif

    assign irq = tpend;

endmodule

// File: tb/tb_data_bus_slave.sv
// tb/tb_data_bus_slave.sv - directed bench for data_bus_slave
module tb_data_bus_slave;

    localparam logic [31:0] IO_BASE = 32'h0000_1000;
    localparam logic [31:0] UNMAP   = 32'hDEDE_AFAF;

    logic        clkIn = 1'b0;
    logic        rst;
    logic [15:0] gpio_out;
    logic        irq;
    logic        err;
    logic        init_done;

    int          compared   = 0;
    int          mismatched = 0;
    int          cycles;
    logic [31:0] rdata;

    data_bus_slave_if bus ();

    data_bus_slave #(
        .ADDR_W  (8),
        .IO_BASE (IO_BASE)
    ) dut (
        .clkIn     (clkIn),
        .rst       (rst),
        .bus       (bus),
        .gpio_out  (gpio_out),
        .irq       (irq),
        .err       (err),
        .init_done (init_done)
    );

    always #5 clkIn = ~clkIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the sampling edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.cs = 1'b1;
        bus.we = 1'b1;
        bus.ADDR = addr;
        bus.DATA_BUS_WRITE = data;
        @(negedge clkIn);
        bus.cs = 1'b0;
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr);
        bus.cs = 1'b1;
        bus.we = 1'b0;
        bus.ADDR = addr;
        @(negedge clkIn);
        bus.cs = 1'b0;
        rdata = bus.DATA_BUS_READ;
    endtask

    task automatic wait_init(input string tag);
        cycles = 0;
        while (init_done !== 1'b1 && cycles < 1000) begin
            bus.cs = (cycles == 10) || (cycles == 20);
            bus.we = (cycles == 10);
            bus.ADDR = (cycles == 10) ? 32'h0 : 32'h800;
            bus.DATA_BUS_WRITE = 32'hDEAD_BEEF;
            @(negedge clkIn);
            cycles++;
        end
        bus.cs = 1'b0;
        bus.we = 1'b0;
        chk(tag, 32'(cycles), 32'd256);
    endtask

    initial begin
        rst = 1'b0;
        bus.cs = 1'b0;
        bus.we = 1'b0;
        bus.ADDR = '0;
        bus.DATA_BUS_WRITE = '0;

        repeat (3) @(negedge clkIn);
        chk("rst_rdata", bus.DATA_BUS_READ, 32'h0);
        chk("rst_gpio", 32'(gpio_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_init_done", 32'(init_done), 32'h0);

        // Clear sweep with a RAM write and an unmapped read injected mid-CLEAR.
        rst = 1'b1;
        wait_init("clear_cycles");
        chk("clear_err_untouched", 32'(err), 32'h0);
        chk("clear_rdata_untouched", bus.DATA_BUS_READ, 32'h0);

        for (int i = 0; i < 256; i++) begin
            rd(32'(i) * 32'd4);
            chk($sformatf("clear_word_%0d", i), rdata, 32'h0);
        end

        wr(32'h010, 32'h1234_5678);
        rd(32'h010);
        chk("ram_rt_010", rdata, 32'h1234_5678);
        rd(32'h014);
        chk("ram_014_zero", rdata, 32'h0);
        rd(32'h010);
        chk("ram_010_again", rdata, 32'h1234_5678);
        wr(32'h020, 32'h5555_5555);
        chk("rdata_hold_on_write", bus.DATA_BUS_READ, 32'h1234_5678);

        wr(32'h3FC, 32'hA5A5_0001);
        rd(32'h3FC);
        chk("ram_last_word", rdata, 32'hA5A5_0001);
        chk("no_err_yet", 32'(err), 32'h0);
        rd(32'h400);
        chk("ram_end_unmapped", rdata, UNMAP);
        chk("ram_end_err", 32'(err), 32'h1);
        wr(IO_BASE + 32'hC, 32'h2);
        chk("err_w1c_1", 32'(err), 32'h0);

        rd(32'h0800);
        chk("unmapped_rd", rdata, UNMAP);
        chk("unmapped_err", 32'(err), 32'h1);
        rd(IO_BASE + 32'hC);
        chk("status_err_bit", rdata, 32'h2);
        wr(IO_BASE + 32'hC, 32'h0);
        chk("status_w0_keeps_err", 32'(err), 32'h1);
        wr(IO_BASE + 32'hC, 32'h2);
        chk("err_w1c_2", 32'(err), 32'h0);

        wr(32'h012, 32'hFFFF_FFFF);
        chk("misaligned_wr_err", 32'(err), 32'h1);
        rd(32'h010);
        chk("misaligned_wr_dropped", rdata, 32'h1234_5678);
        wr(IO_BASE + 32'hC, 32'h2);
        rd(32'h011);
        chk("misaligned_rd", rdata, UNMAP);
        chk("misaligned_rd_err", 32'(err), 32'h1);
        wr(IO_BASE + 32'hC, 32'h2);
        wr(IO_BASE + 32'h10, 32'h1);
        chk("unmapped_wr_err", 32'(err), 32'h1);
        wr(IO_BASE + 32'hC, 32'h2);
        chk("err_w1c_3", 32'(err), 32'h0);

        wr(IO_BASE, 32'hFFFF_A5A5);
        chk("gpio_out", 32'(gpio_out), 32'h0000_A5A5);
        rd(IO_BASE);
        chk("gpio_readback", rdata, 32'h0000_A5A5);

`ifdef DATA_BUS_SLAVE_TIMER_EN
        wr(IO_BASE + 32'h8, 32'd20);
        rd(IO_BASE + 32'h8);
        chk("tcmp_readback", rdata, 32'd20);
        wr(IO_BASE + 32'h4, 32'hFFFF);
        repeat (20) @(negedge clkIn);
        chk("irq_before_match", 32'(irq), 32'h0);
        @(negedge clkIn);
        chk("irq_at_21", 32'(irq), 32'h1);
        rd(IO_BASE + 32'hC);
        chk("status_irq_bit", rdata, 32'h1);
        wr(IO_BASE + 32'hC, 32'h1);
        chk("irq_w1c", 32'(irq), 32'h0);
        wr(IO_BASE + 32'h4, 32'h0);
        repeat (20) @(negedge clkIn);
        chk("irq_cleared_pre_match", 32'(irq), 32'h0);
        wr(IO_BASE + 32'hC, 32'h1);
        chk("irq_set_beats_clear", 32'(irq), 32'h1);
        chk("timer_no_err", 32'(err), 32'h0);
`else
        wr(IO_BASE + 32'h4, 32'h5);
        chk("tcount_wr_no_err", 32'(err), 32'h0);
        wr(IO_BASE + 32'h8, 32'h1);
        chk("tcmp_wr_no_err", 32'(err), 32'h0);
        rd(IO_BASE + 32'h4);
        chk("tcount_reads_0", rdata, 32'h0);
        rd(IO_BASE + 32'h8);
        chk("tcmp_reads_0", rdata, 32'h0);
        repeat (30) @(negedge clkIn);
        chk("irq_tied_0", 32'(irq), 32'h0);
        rd(IO_BASE + 32'hC);
        chk("status_no_timer", rdata, 32'h0);
`endif

        // Reset in the middle of operation restarts the clear sweep.
        wr(32'h000, 32'hCAFE_F00D);
        rst = 1'b0;
        @(negedge clkIn);
        rst = 1'b1;
        chk("midrst_init_done", 32'(init_done), 32'h0);
        chk("midrst_gpio", 32'(gpio_out), 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        chk("midrst_rdata", bus.DATA_BUS_READ, 32'h0);
        wait_init("midrst_clear_cycles");
        rd(32'h000);
        chk("midrst_word0", rdata, 32'h0);
        rd(32'h010);
        chk("midrst_word4", rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_bus_slave.md
# data_bus_slave

Memory-mapped data-bus slave directly downstream of `cpu`. It consumes `cs`/`we`/`ADDR`/`DATA_BUS_WRITE` and produces `DATA_BUS_READ`. It provides a word-addressed data RAM, a GPIO output register, a status register and an optional compare timer. After reset it zero-fills the RAM and signals `init_done`; the top level holds the CPU in reset until `init_done` is high.

## Interface
- `ADDR_W`, 8: RAM word-address width; the RAM holds 2^ADDR_W 32-bit words.
- `IO_BASE`, 32'h0000_1000: base byte address of the I/O register block.
- `clkIn` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `cs` in 1: access strobe, sampled on each rising edge.
- `we` in 1: 1 selects write, 0 selects read; valid only while `cs`=1.
- `ADDR` in 32: byte address.
- `DATA_BUS_WRITE` in 32: write data.
- `DATA_BUS_READ` out 32: registered read data.
- `gpio_out` out 16: GPIO register, bits [15:0].
- `irq` out 1: timer interrupt pending.
- `err` out 1: sticky bus-error flag.
- `init_done` out 1: high once the RAM clear is complete.

## Operation
- **FSM states:**
  - CLEAR is entered on reset. Each cycle it writes 0 to RAM[clr_idx] and increments `clr_idx`. When `clr_idx` = 2^ADDR_W−1 has been written, it moves to RUN.
  - RUN stays in RUN until the next reset.
- **Bus accesses in CLEAR** are ignored: no write, no read update, `err` unchanged.
- **Address decode in RUN**, applied when `cs`=1:
  - `ADDR` < 4·2^ADDR_W: RAM access at word index `ADDR[ADDR_W+1:2]`.
  - `IO_BASE`+0x0 GPIO: read/write, bits [15:0]; upper bits read as 0.
  - `IO_BASE`+0x4 TCOUNT: reads the count; any write clears it to 0.
  - `IO_BASE`+0x8 TCMP: read/write.
  - `IO_BASE`+0xC STATUS: bit0 = irq pending, bit1 = err. Writing 1 to a bit clears it (W1C).
  - Any other address is unmapped. A read returns 32'hDEDE_AFAF and a write is dropped. Either access sets `err`.
- **Misalignment:** `ADDR[1:0]`≠0 sets `err` and the access is dropped. A dropped read returns 32'hDEDE_AFAF.
- **Timer:**
  - TCOUNT increments every RUN cycle and wraps from 32'hFFFF_FFFF to 0.
  - When TCMP≠0 and TCOUNT==TCMP, irq pending is set.
  - If a set and a W1C clear occur in the same cycle, the set wins. This applies to irq and to err.
- A write to TCOUNT overrides that cycle's increment: the next value is 0.

## Timing
- **Reset values:**
  - `DATA_BUS_READ`=0, `gpio_out`=0, `irq`=0, `err`=0, `init_done`=0.
  - TCOUNT=0, TCMP=0, `clr_idx`=0, state=CLEAR.
  - RAM contents are defined only by the clear sweep.
- **Clear duration:** exactly 2^ADDR_W cycles after the first edge with `rst`=1. `init_done` rises at the edge that enters RUN.
- **Read latency:** `DATA_BUS_READ` updates at the edge after the `cs`&!`we` sample, i.e. 1 cycle. It holds its value until the next accepted read.
- **Writes** take effect at the sampling edge. A read of the same address on the next cycle returns the new value.
- **Reset mid-operation:** an edge with `rst`=0 restarts CLEAR from index 0 and drops any in-flight access.
- **Output timing:** `irq` is high the cycle after the match. `err` is high the cycle after the offending access.

## Configuration
- **With `DATA_BUS_SLAVE_TIMER_EN` defined:** TCOUNT, TCMP, irq and STATUS bit0 are present as described above.
- **Without it:**
  - TCOUNT and TCMP read as 0, writes to them are accepted and dropped, and they do not set `err`.
  - `irq` is tied to 0 and STATUS bit0 reads 0.
  - No counter flops are synthesised.

## Structure
- **Package `data_bus_slave_pkg`** holds:
  - the register offsets: `OFF_GPIO`, `OFF_TCOUNT`, `OFF_TCMP`, `OFF_STATUS`;
  - `BUS_UNMAPPED_DATA` = 32'hDEDE_AFAF;
  - the FSM state typedef `{ST_CLEAR, ST_RUN}`.
- **Sub-module `data_bus_timer`:**
  - Contents: count, compare, match and pending logic.
  - Inputs: `clkIn`, `rst`, `run`, `wr_count`, `wr_cmp`, `clr_pend`, `wdata`.
  - Outputs: `count`, `cmp`, `pend`.
  - Instantiated only under `DATA_BUS_SLAVE_TIMER_EN`.
- RAM is an inferred single-port array inside the top module.

## Test plan
- **Reset/clear:** hold `rst`=0 for 3 cycles, then release.
  - `init_done` rises after exactly 256 cycles.
  - All reads of RAM 0x000–0x3FC then return 0.
- **RAM round trip:** write 32'h1234_5678 to 0x010, then read 0x010 on the next cycle.
  - `DATA_BUS_READ`=32'h1234_5678 one cycle later.
  - An interleaved read of 0x014 returns 0.
- **Errors:**
  - Read of 0x0800 returns 32'hDEDE_AFAF and `err`=1.
  - A write of 32'h2 to STATUS clears `err`.
  - A write to 0x012 (misaligned) sets `err` and leaves RAM[4] unchanged.
- **GPIO:** write 32'hFFFF_A5A5 to `IO_BASE`.
  - `gpio_out`=16'hA5A5.
  - Readback returns 32'h0000_A5A5.
- **Timer (macro on):**
  - Write TCMP=20 and clear TCOUNT; `irq` rises 21 cycles after the TCOUNT write.
  - A W1C write of 1 to STATUS issued in a matching cycle leaves `irq`=1.
- **Timer (macro off) and CLEAR gating:**
  - With the macro off, TCOUNT reads 0 and `irq` stays 0.
  - A write during CLEAR to 0x000 is lost and reads 0 after `init_done`.
